// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch button front end and run/lap/pause controller
// Buttons are synchronized and debounced, then drive the FSM that gates and clears the external counter.
module stopwatch_ctrl #(
  parameter int BITS      = 29,
  parameter int DB_CYCLES = 16
) (
  input  logic            NEclk,
  input  logic            reset,
  input  logic            btn_ss,
  input  logic            btn_lr,
  input  logic [BITS-1:0] count_in,
  output logic            count_en,
  output logic            count_clr,
  output logic [BITS-1:0] disp_count,
  output logic [1:0]      state
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_LAP   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  // Index 0 is start/stop, index 1 is lap/reset.
  logic [1:0]         sync1_q, sync1_d;
  logic [1:0]         sync2_q, sync2_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         press_q, press_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;

  logic [1:0]      state_q, state_d;
  logic [BITS-1:0] lap_q, lap_d;
  logic            hold_q, hold_d;
  logic            en_q, en_d;
  logic            clr_q, clr_d;

  logic ss, lr;

  always_comb begin
    sync1_d = {btn_lr, btn_ss};
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    press_d = '0;
    cnt_d   = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]   = '0;
        lvl_d[i]   = sync2_q[i];
        press_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  assign ss = press_q[0];
  assign lr = press_q[1];

  // Start/stop takes priority whenever both presses land on the same edge.
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    hold_d  = hold_q;
    clr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss) begin
          state_d = S_PAUSE;
        end else if (lr) begin
          state_d = S_LAP;
          lap_d   = count_in;
          hold_d  = 1'b1;
        end
      end
      S_LAP: begin
        if (ss) begin
          state_d = S_PAUSE;
        end else if (lr) begin
          state_d = S_RUN;
          hold_d  = 1'b0;
        end
      end
      default: begin
        if (ss) begin
          state_d = S_RUN;
          hold_d  = 1'b0;
        end else if (lr) begin
          state_d = S_IDLE;
          lap_d   = '0;
          hold_d  = 1'b0;
          clr_d   = 1'b1;
        end
      end
    endcase
    en_d = (state_d == S_RUN) || (state_d == S_LAP);
  end

  always_ff @(negedge NEclk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      cnt_q   <= '0;
      state_q <= S_IDLE;
      lap_q   <= '0;
      hold_q  <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      lap_q   <= lap_d;
      hold_q  <= hold_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
    end
  end

  assign disp_count = hold_q ? lap_q : count_in;
  assign state      = state_q;
  assign count_en   = en_q;
  assign count_clr  = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl
// Stimulus predicts each press outcome from the mode rules and queues it; a monitor compares on the due cycle.
module tb_stopwatch_ctrl;
  localparam int BITS = 29;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
  localparam int LAT = 19;

  logic            NEclk;
  logic            reset;
  logic            btn_ss, btn_lr;
  logic [BITS-1:0] count_in;
  logic            count_en, count_clr;
  logic [BITS-1:0] disp_count;
  logic [1:0]      state;

  stopwatch_ctrl #(.BITS(BITS), .DB_CYCLES(16)) dut (
    .NEclk(NEclk), .reset(reset), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .count_in(count_in), .count_en(count_en), .count_clr(count_clr),
    .disp_count(disp_count), .state(state)
  );

  initial NEclk = 1'b0;
  always #5 NEclk = ~NEclk;

  int unsigned ncyc = 0;
  always @(negedge NEclk) ncyc <= ncyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int unsigned     cyc;
    int              st;
    logic            clr;
    logic            hold;
    logic [BITS-1:0] lap;
  } exp_t;
  exp_t sb[$];

  int              m_st = M_IDLE;
  logic            m_hold = 1'b0;
  logic [BITS-1:0] m_lap = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, ncyc);
  endtask

  task automatic push(input int unsigned c, input logic clr);
    exp_t e;
    e.cyc = c; e.st = m_st; e.clr = clr; e.hold = m_hold; e.lap = m_lap;
    sb.push_back(e);
  endtask

  // Mode rules: start/stop wins over lap/reset; the display holds the lap value
  // in LAP and in a pause that was entered from LAP.
  task automatic model_event(input bit ss, input bit lr, input logic [BITS-1:0] cnt, output logic clr);
    clr = 1'b0;
    if (ss) begin
      if (m_st == M_IDLE) m_st = M_RUN;
      else if (m_st == M_RUN || m_st == M_LAP) m_st = M_PAUSE;
      else begin m_st = M_RUN; m_hold = 1'b0; end
    end else if (lr) begin
      if (m_st == M_RUN) begin m_st = M_LAP; m_lap = cnt; m_hold = 1'b1; end
      else if (m_st == M_LAP) begin m_st = M_RUN; m_hold = 1'b0; end
      else if (m_st == M_PAUSE) begin m_st = M_IDLE; m_lap = '0; m_hold = 1'b0; clr = 1'b1; end
    end
  endtask

  // External counter: cleared by count_clr, advanced by count_en.
  task automatic tick();
    @(posedge NEclk);
    if (count_clr) count_in = '0;
    else if (count_en) count_in = count_in + 1'b1;
  endtask

  task automatic push_now();
    tick();
    push(ncyc, 1'b0);
  endtask

  task automatic set_count(input logic [BITS-1:0] v);
    tick();
    count_in = v;
    push(ncyc, 1'b0);
  endtask

  task automatic press(input bit ss, input bit lr, input int hold_c, input int gap_c,
                       input bit force_en, input logic [BITS-1:0] force_v, input bit rel_rst);
    int unsigned n0;
    logic clr;
    tick();
    n0 = ncyc;
    btn_ss = ss;
    btn_lr = lr;
    if (rel_rst) reset = 1'b1;
    while (ncyc != n0 + LAT - 1) tick();
    if (force_en) count_in = force_v;
    push(n0 + LAT - 1, 1'b0);
    model_event(ss, lr, count_in, clr);
    push(n0 + LAT, clr);
    push(n0 + LAT + 1, 1'b0);
    push(n0 + LAT + 2, 1'b0);
    repeat (hold_c - (LAT - 1)) tick();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (gap_c) tick();
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    m_st = M_IDLE; m_hold = 1'b0; m_lap = '0;
    push(ncyc, 1'b0);
    tick();
    push(ncyc, 1'b0);
    tick();
    reset = 1'b1;
    push(ncyc, 1'b0);
    push(ncyc + 1, 1'b0);
    push(ncyc + 2, 1'b0);
    repeat (4) tick();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge NEclk);
      #2;
      chk("clr_en_exclusive", {62'd0, count_clr, count_en} == 2'b11, 1'b0);
      while (sb.size() > 0 && sb[0].cyc <= ncyc) begin
        e = sb.pop_front();
        if (e.cyc != ncyc) begin
          n_total++;
          $display("FAIL schedule: entry for cycle %0d reached at cycle %0d", e.cyc, ncyc);
        end else begin
          chk("state", state, e.st);
          chk("count_en", count_en, (e.st == M_RUN || e.st == M_LAP));
          chk("count_clr", count_clr, e.clr);
          chk("disp_count", disp_count, e.hold ? e.lap : count_in);
        end
      end
    end
  end

  initial begin
    logic [BITS-1:0] top;
    int r, k;
    reset = 1'b0;
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    count_in = '0;
    repeat (3) tick();
    push(ncyc, 1'b0);
    btn_ss = 1'b1;
    repeat (2) push_now();

    // Button already held when reset releases counts as a fresh press.
    press(1, 0, 20, 25, 0, '0, 1);
    press(0, 1, 24, 25, 1, BITS'(36700), 0);
    press(1, 0, 22, 25, 0, '0, 0);
    press(0, 1, 22, 25, 0, '0, 0);
    press(1, 0, 22, 25, 0, '0, 0);
    press(1, 1, 22, 25, 1, BITS'(1234), 0);
    set_count(BITS'(999));
    push_now();
    press(1, 0, 22, 25, 0, '0, 0);
    press(0, 1, 22, 25, 1, BITS'(500), 0);
    do_reset();

    press(1, 0, 22, 25, 0, '0, 0);
    btn_ss = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat (5) tick();
      btn_ss = ~btn_ss;
    end
    btn_ss = 1'b0;
    repeat (25) tick();
    push_now();

    top = '1;
    set_count(top - BITS'(3));
    repeat (10) tick();
    push_now();

    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 7);
      if (r == 7) do_reset();
      else press(r < 3 || r == 6, r >= 3, $urandom_range(20, 30), $urandom_range(20, 35),
                 1'($urandom_range(0, 1)), BITS'($urandom()), 0);
    end

    k = 0;
    while (sb.size() > 0 && k < 100) begin
      tick();
      k++;
    end
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries never checked", sb.size());
    end
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
